// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module : adder_pkg
// Brief  : Shared constants and FSM state type for the nibble-serial adder.
// Rev    : 1.0
// ============================================================================
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

endpackage
`default_nettype wire

// File: rtl/ripple_adder.sv
`default_nettype none
// ============================================================================
// Module : ripple_adder
// Brief  : 4-bit ripple-carry adder slice (Sum = A + B + Cin).
// Rev    : 1.0
// ============================================================================
module ripple_adder
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = carry[NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module : nibble_serial_adder
// Brief  : WIDTH-bit adder computed one nibble per clock through a 4-bit slice.
// Rev    : 1.0
// ============================================================================
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  nsa_state_t             state;
  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-1:0]       res;
  logic                   carry;

  logic [NIBBLE_W-1:0]    slice_sum;
  logic                   slice_cout;
  logic [WIDTH+NIBBLE_W-1:0] res_cat;
  logic                   accept;

  ripple_adder u_slice (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign sum       = res;
  assign cout      = carry;

  // New slice result enters at the top; after N shifts nibble 0 sits at the bottom.
  assign res_cat = {slice_sum, res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          res   <= res_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          carry <= slice_cout;
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              a_sh  <= a;
              b_sh  <= b;
              carry <= cin;
              cnt   <= '0;
              state <= CALC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that takes a WIDTH-bit operand pair over a valid/ready handshake and computes the sum four bits per clock by sequencing the existing 4-bit `ripple_adder` slice. A registered carry is chained between nibbles. The block sits directly around the 4-bit adder: it feeds that adder one nibble per cycle and consumes its Sum/Cout. It trades latency for area wherever a wide add is needed without a wide carry chain.

## Interface
- `WIDTH`, default 16: operand/result width. Must be a multiple of 4 and ≥ 4; any other value is an elaboration error.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept an operand pair.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry into nibble 0.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  A + B + cin, modulo 2^WIDTH.
- `cout`  out  1  carry out of the top nibble.
- `busy`  out  1  high while in CALC.

## Operation
- N = WIDTH/4 nibbles.
- The FSM has three states: IDLE, CALC, DONE.
- **Accept:** an operand pair is accepted on any edge where `in_valid && in_ready`.
  - `a`, `b` and `cin` are latched into shift registers A_sh, B_sh and the carry register.
  - The nibble counter is cleared.
  - The state goes to CALC.
  - Inputs are ignored after acceptance.
- **CALC:** each cycle, A_sh[3:0], B_sh[3:0] and the carry register drive the 4-bit adder slice. On the next edge:
  - the slice Sum shifts into the top nibble of the result register (shift right by 4);
  - A_sh and B_sh shift right by 4;
  - the carry register takes the slice Cout;
  - the counter increments.
  - After nibble N-1 is processed, the state goes to DONE.
- **DONE:**
  - `out_valid` = 1.
  - `sum` = the result register and `cout` = the carry register; both are held stable until the handshake.
  - On `out_ready`, the state goes to IDLE, unless a new accept occurs on the same edge, in which case it goes to CALC.
- `in_ready` = (state == IDLE) || (state == DONE && out_ready). This is combinational from state and `out_ready`, which allows back-to-back operations.
- `out_valid` and `busy` are decoded from registered state.
- **Reset, asserted at any time including mid-CALC:**
  - state returns to IDLE;
  - counter, shift registers, result register and carry register are cleared;
  - no partial result is ever presented.
- **Reset values:** `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, `in_ready`=1.

## Timing
- Accept on edge E0. CALC occupies the cycles after E0 through edge E0+N.
- `out_valid` rises after edge E0+N: latency is N cycles (4 for WIDTH=16).
- Minimum initiation interval is N+1 cycles, when `out_ready` is held high and `in_valid` is waiting.
- With `out_ready` low, DONE holds indefinitely with `sum`/`cout` unchanged and `in_ready`=0.
- **Simultaneous events:**
  - `out_ready` and `in_valid` in the same DONE cycle complete the result and accept the new pair on one edge.
  - `in_valid` during CALC is ignored (`in_ready`=0).
- **Wrap-around:** the sum is truncated to WIDTH bits. Overflow is reported only via `cout`; there is no signed overflow flag.
- **Counter:** width is $clog2(N) with a minimum of 1. It terminates at N-1 and never wraps during CALC.

## Structure
- Package `adder_pkg` holds:
  - the `NIBBLE_W` = 4 constant;
  - the state typedef `nsa_state_t` {IDLE, CALC, DONE}.
- Sub-module: one instance of the existing 4-bit `ripple_adder` as the nibble slice. No other sub-modules.
- The FSM, counter and shift registers live in `nibble_serial_adder` itself.

## Test plan
All scenarios use WIDTH=16.
- **Reset:** assert `rst_n`=0 mid-simulation with random inputs -> `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, `in_ready`=1, all checked while reset is held.
- **Basic add:** a=0x00FF, b=0x0001, cin=0, `out_ready`=1 -> `sum`=0x0100, `cout`=0; `out_valid` high exactly 4 cycles after the accept edge and high for 1 cycle; `busy` high for 4 cycles.
- **Full carry ripple:** a=0xFFFF, b=0x0000, cin=1 -> `sum`=0x0000, `cout`=1. Also a=0x8000, b=0x8000, cin=0 -> `sum`=0x0000, `cout`=1.
- **Backpressure:** a=0x1234, b=0x4321, `out_ready` low for 3 cycles after `out_valid` -> `sum`=0x5555 held stable and `in_ready`=0 throughout. Then raise `out_ready` with `in_valid` (a=0x0001, b=0x0001) on the same edge -> second pair accepted with no idle cycle, `sum`=0x0002 four cycles later.
- **Reset mid-CALC:** accept a=0xABCD, b=0x1111; pulse `rst_n` low during nibble 2 -> `out_valid` never asserts for that pair. A following accept of a=0x0F0F, b=0xF0F0, cin=1 -> `sum`=0x0000, `cout`=1.
- **Input isolation:** change `a`/`b`/`cin` every cycle during CALC -> result equals the sum of the values latched at accept.
